// File: rtl/keypad_time_entry_pkg.sv
// Shared definitions for the keypad time-entry block: key codes,
// field indices, FSM state encoding and decode/legality helpers.
package keypad_time_entry_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [2:0] FLD_H_TENS = 3'd0;
    localparam logic [2:0] FLD_H_ONES = 3'd1;
    localparam logic [2:0] FLD_M_TENS = 3'd2;
    localparam logic [2:0] FLD_M_ONES = 3'd3;
    localparam logic [2:0] FLD_S_TENS = 3'd4;
    localparam logic [2:0] FLD_S_ONES = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_CONFIRM,
        ST_COMMIT
    } entry_state_t;

    // Map a one-hot keypad pattern to its key code (bit 10 is digit 0).
    function automatic logic [3:0] key_code_of(input logic [11:0] keys);
        logic [3:0] code;
        code = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (keys[i]) code = 4'(i + 1);
        end
        if (keys[9])  code = KEY_STAR;
        if (keys[10]) code = 4'd0;
        if (keys[11]) code = KEY_HASH;
        return code;
    endfunction

    // Range check of a digit for the field it would be written into.
    function automatic logic digit_legal(input logic [2:0] pos,
                                         input logic [3:0] digit,
                                         input logic [3:0] h_tens);
        logic ok;
        case (pos)
            FLD_H_TENS:             ok = (digit <= 4'd2);
            FLD_H_ONES:             ok = (h_tens == 4'd2) ? (digit <= 4'd3) : (digit <= 4'd9);
            FLD_M_TENS, FLD_S_TENS: ok = (digit <= 4'd5);
            default:                ok = (digit <= 4'd9);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/keypad_time_entry_if.sv
// Keypad input and time-entry result bundle. The master is the entry
// block; the slave is the keypad driver / clock-alarm core side.
interface keypad_time_entry_if;
    logic        arm;
    logic [11:0] keypad_in;
    logic        entry_active;
    logic [2:0]  digit_pos;
    logic        pending_valid;
    logic [3:0]  pending_digit;
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic        commit;
    logic        err;

    modport master (
        input  arm, keypad_in,
        output entry_active, digit_pos, pending_valid, pending_digit,
               hh, mm, ss, commit, err
    );

    modport slave (
        output arm, keypad_in,
        input  entry_active, digit_pos, pending_valid, pending_digit,
               hh, mm, ss, commit, err
    );
endinterface

// File: rtl/keypad_time_entry_debounce.sv
// Keypad debouncer: accepts a one-hot pattern after DEBOUNCE_CYCLES
// identical samples, emits one key event, then waits for full release.
module keypad_debounce
    import keypad_time_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [11:0] keypad_in,
    output logic        key_event,
    output logic [3:0]  key_code
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] run;
    logic [11:0]   last;
    logic          armed;
    logic          one_hot;

    // Run length including the current sample.
    always_comb begin
        one_hot = (keypad_in != '0) && ((keypad_in & (keypad_in - 12'd1)) == '0);
        run     = (cnt != '0 && keypad_in == last) ? cnt + 1'b1 : CW'(1);
    end

    // Stability counter, release re-arm and registered event output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            last      <= '0;
            armed     <= 1'b1;
            key_event <= 1'b0;
            key_code  <= '0;
        end else begin
            key_event <= 1'b0;
            if (keypad_in == '0) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else if (!one_hot) begin
                cnt <= '0;
            end else if (armed) begin
                if (run == CW'(DEBOUNCE_CYCLES)) begin
                    key_event <= 1'b1;
                    key_code  <= key_code_of(keypad_in);
                    armed     <= 1'b0;
                    cnt       <= '0;
                end else begin
                    cnt  <= run;
                    last <= keypad_in;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: six confirmed BCD digits then '*' commits HH:MM:SS.
// Optional inactivity timeout under KEY_ENTRY_TIMEOUT_EN.
module keypad_time_entry
    import keypad_time_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input logic                 clk,
    input logic                 resetn,
    keypad_time_entry_if.master bus
);

    logic         key_event;
    logic [3:0]   key_code;

    entry_state_t state, state_n;
    logic [2:0]   pos, pos_n;
    logic         pv, pv_n;
    logic [3:0]   pd, pd_n;
    logic [5:0][3:0] sh, sh_n;
    logic [7:0]   hh_q, hh_n, mm_q, mm_n, ss_q, ss_n;
    logic         commit_q, commit_n, err_q, err_n;

    keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk       (clk),
        .resetn    (resetn),
        .keypad_in (bus.keypad_in),
        .key_event (key_event),
        .key_code  (key_code)
    );

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state != ST_IDLE) && bus.arm && !key_event &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inactivity counter, restarted by any key event or while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  tmo_cnt <= '0;
        else if (key_event || state == ST_IDLE || tmo_hit) tmo_cnt <= '0;
        else                                          tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    // Next-state and datapath decisions; arm low overrides any key event.
    always_comb begin
        state_n  = state;
        pos_n    = pos;
        pv_n     = pv;
        pd_n     = pd;
        sh_n     = sh;
        hh_n     = hh_q;
        mm_n     = mm_q;
        ss_n     = ss_q;
        commit_n = 1'b0;
        err_n    = 1'b0;
        if (!bus.arm) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_DIGIT;
                    pos_n   = '0;
                    pv_n    = 1'b0;
                    sh_n    = '0;
                end
                ST_DIGIT, ST_CONFIRM: begin
                    if (key_event) begin
                        if (key_code == KEY_STAR) begin
                            err_n   = 1'b1;
                            sh_n    = '0;
                            pv_n    = 1'b0;
                            pd_n    = '0;
                            pos_n   = '0;
                            state_n = ST_DIGIT;
                        end else if (key_code <= 4'd9) begin
                            if (digit_legal(pos, key_code, sh[FLD_H_TENS])) begin
                                pd_n    = key_code;
                                pv_n    = 1'b1;
                                state_n = ST_CONFIRM;
                            end else begin
                                err_n = 1'b1;
                            end
                        end else if (key_code == KEY_HASH && state == ST_CONFIRM) begin
                            sh_n[pos] = pd;
                            pv_n      = 1'b0;
                            if (pos == FLD_S_ONES) begin
                                state_n = ST_COMMIT;
                            end else begin
                                pos_n   = pos + 1'b1;
                                state_n = ST_DIGIT;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    if (key_event && key_code == KEY_STAR) begin
                        hh_n     = {sh[FLD_H_TENS], sh[FLD_H_ONES]};
                        mm_n     = {sh[FLD_M_TENS], sh[FLD_M_ONES]};
                        ss_n     = {sh[FLD_S_TENS], sh[FLD_S_ONES]};
                        commit_n = 1'b1;
                        pos_n    = '0;
                        state_n  = ST_DIGIT;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
`ifdef KEY_ENTRY_TIMEOUT_EN
            if (tmo_hit) begin
                err_n   = 1'b1;
                sh_n    = '0;
                pv_n    = 1'b0;
                pd_n    = '0;
                pos_n   = '0;
                state_n = ST_DIGIT;
            end
`endif
        end
    end

    // State and datapath registers; commit/err are registered so they
    // coincide with the updated outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            pos      <= '0;
            pv       <= 1'b0;
            pd       <= '0;
            sh       <= '0;
            hh_q     <= '0;
            mm_q     <= '0;
            ss_q     <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            pv       <= pv_n;
            pd       <= pd_n;
            sh       <= sh_n;
            hh_q     <= hh_n;
            mm_q     <= mm_n;
            ss_q     <= ss_n;
            commit_q <= commit_n;
            err_q    <= err_n;
        end
    end

    assign bus.entry_active  = (state != ST_IDLE);
    assign bus.digit_pos     = pos;
    assign bus.pending_valid = pv;
    assign bus.pending_digit = pd;
    assign bus.hh            = hh_q;
    assign bus.mm            = mm_q;
    assign bus.ss            = ss_q;
    assign bus.commit        = commit_q;
    assign bus.err           = err_q;

endmodule
